mb16_acc: RTL and testbench
===========================

// Module: mb16_acc
// PURPOSE
//  Dot-product accumulator directly downstream of the registered 16x16 radix-4 Booth multiplier stage.
//  Consumes its signed 2*WIDTH-bit products one per cycle via valid/ready.
//  Sums each vector of cfg_len products into a saturating ACCW-bit accumulator.
//  Presents each vector result on a valid/ready output port; the output holds under backpressure.
// PARAMETERS
//  WIDTH  16  multiplier operand width; product width PW = 2*WIDTH
//  ACCW   40  accumulator/result width, signed, must be >= 2*WIDTH+1
//  LENW   8   width of vector-length config and internal term counter
// PORTS
//  CLK        in   1          clock, all state updates on rising edge
//  RST        in   1          synchronous active-low reset
//  in_valid   in   1          product valid
//  in_ready   out  1          accumulator can take a product this cycle
//  product    in   2*WIDTH    signed product from the multiplier stage
//  cfg_len    in   LENW       terms per vector; sampled on the first term; 0 is treated as 1
//  out_valid  out  1          acc_out holds a completed vector result
//  out_ready  in   1          consumer accepts the result
//  acc_out    out  ACCW       signed, saturated vector sum
//  ovf        out  1          saturation occurred in this vector; qualified by out_valid
//  busy       out  1          vector in progress (state != IDLE)
// BEHAVIOUR
//  Reset (RST==0 at posedge): state=IDLE; acc_out=0; out_valid=0; ovf=0; cnt=0; len_q=0.
//    Applies in any state; a partial vector is discarded and a pending result is dropped.
//  Handshakes
//    Input xfer = in_valid & in_ready. Output xfer = out_valid & out_ready.
//    product and cfg_len are don't-care when in_valid=0.
//  Sign extension: product is sign-extended to ACCW bits (sx) before the add.
//  Saturating add: sum = acc + sx, computed at ACCW+1 bits.
//    Above 2^(ACCW-1)-1 -> clamp to max. Below -2^(ACCW-1) -> clamp to min.
//    On clamp, set the sticky ovf for the current vector.
//  FSM states and transitions
//    IDLE: in_ready=1.
//      On xfer: acc=sx; ovf=0; cnt=1; len_q=max(cfg_len,1).
//      Next state is HOLD if len_q==1, else ACC.
//    ACC: in_ready=1.
//      On xfer: acc=sat(acc+sx); cnt=cnt+1.
//      When cnt+1==len_q the vector is complete -> HOLD.
//      No xfer -> hold all state; bubbles are allowed.
//    HOLD: out_valid=1; acc_out and ovf stable.
//      in_ready=out_ready (combinational); this allows a back-to-back vector.
//      Output xfer without input xfer -> IDLE, out_valid=0.
//      Output xfer with same-cycle input xfer -> treated as an IDLE first term; next state is ACC or HOLD per new len_q.
//      No output xfer -> stay; in_ready=0; no product is consumed.
//  acc_out is the accumulator register, driven as a register output.
//  Latency: out_valid rises the cycle after the last term's input xfer.
//    Min throughput is one product per cycle; a result costs 0 extra cycles when out_ready=1.
//  cfg_len changes mid-vector have no effect until the next first term.
//  Counter: cnt never wraps; max vector length is 2^LENW-1.
// TESTING
//  1. len=4; products 1000, 2000, -500, 7 on consecutive cycles; out_ready=1
//     -> out_valid one cycle after 4th xfer; acc_out=2507; ovf=0; 1-cycle pulse.
//  2. ACCW=34; len=5; product=0x7FFFFFFF x5
//     -> acc_out=0x1_FFFFFFFF (2^33-1), ovf=1; next vector of len=1, product=-3 -> acc_out=-3, ovf=0.
//  3. Vector done with out_ready=0 for 5 cycles and in_valid=1
//     -> in_ready=0, acc_out/out_valid stable, no product lost; out_ready=1 -> handoff, next vector accepted same cycle.
//  4. cfg_len=0 and cfg_len=1, product=-32768*32767
//     -> acc_out=-1073709056 one cycle later; cfg_len=1 streams one result per cycle.
//  5. len=3 with in_valid gaps (1,0,0,1,0,1) and products 5,6,7
//     -> acc_out=18; cfg_len changed to 9 after first term is ignored.
//  6. RST=0 for one cycle after 2 of 4 terms, then a fresh len=2 vector 10,20
//     -> outputs 0 after reset; result 30, no residue from the aborted vector.

Source files
------------

// File: rtl/mb16_acc_if.sv
// Product-in / result-out bus for the dot-product accumulator.
// The slave side belongs to the accumulator; the master side belongs to whatever
// drives products in and collects results (multiplier stage plus consumer).
interface mb16_acc_if #(
  parameter int WIDTH = 16,
  parameter int ACCW  = 40,
  parameter int LENW  = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   product;
  logic [LENW-1:0]      cfg_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACCW-1:0]      acc_out;
  logic                 ovf;

  modport master (
    output in_valid, product, cfg_len, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, product, cfg_len, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mb16_acc.sv
// Saturating dot-product accumulator behind the 16x16 Booth multiplier stage.
// Sums cfg_len signed products per vector into an ACCW-bit accumulator and
// presents each vector result on a valid/ready port that holds under backpressure.
module mb16_acc #(
  parameter int WIDTH = 16,
  parameter int ACCW  = 40,
  parameter int LENW  = 8
) (
  input  logic         CLK,
  input  logic         RST,
  mb16_acc_if.slave    bus,
  output logic         busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ACCW-1:0]     acc_r;
  logic [ACCW-1:0]     acc_nxt_s;
  logic                ovf_r;
  logic                ovf_nxt_s;
  logic [LENW-1:0]     cnt_r;
  logic [LENW-1:0]     cnt_nxt_s;
  logic [LENW-1:0]     len_q_r;
  logic [LENW-1:0]     len_q_nxt_s;
  logic                out_valid_r;
  logic                busy_r;

  logic                in_ready_s;
  logic                in_xfer_s;
  logic                out_xfer_s;
  logic                start_s;
  logic [ACCW-1:0]     sx_s;
  logic [LENW-1:0]     len_eff_s;
  logic [ACCW:0]       sat_s;

  // Widened add of two ACCW-bit signed values; returns {clamped, result}.
  function automatic logic [ACCW:0] sat_add(input logic [ACCW-1:0] a,
                                            input logic [ACCW-1:0] b);
    logic [ACCW:0] wide;
    wide = {a[ACCW-1], a} + {b[ACCW-1], b};
    if (wide[ACCW] != wide[ACCW-1]) begin
      if (wide[ACCW]) begin
        return {1'b1, 1'b1, {(ACCW-1){1'b0}}};
      end else begin
        return {1'b1, 1'b0, {(ACCW-1){1'b1}}};
      end
    end else begin
      return {1'b0, wide[ACCW-1:0]};
    end
  endfunction

  assign sx_s       = {{(ACCW-PW){bus.product[PW-1]}}, bus.product};
  assign len_eff_s  = (bus.cfg_len == {LENW{1'b0}}) ? LEN_ONE : bus.cfg_len;
  assign in_xfer_s  = bus.in_valid & in_ready_s;
  assign out_xfer_s = out_valid_r & bus.out_ready;
  // In HOLD an input transfer can only happen alongside the output handoff,
  // so any transfer outside ACC is the first term of a new vector.
  assign start_s    = in_xfer_s & (state_r != ACC);
  assign sat_s      = sat_add(acc_r, sx_s);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc_r;
  assign bus.ovf       = ovf_r;
  assign busy          = busy_r;

  // Input readiness: open except while a result waits on a stalled consumer.
  always_comb begin
    in_ready_s = 1'b1;
    case (state_r)
      HOLD:    in_ready_s = bus.out_ready;
      default: in_ready_s = 1'b1;
    endcase
  end

  // Next-state and datapath update for the vector FSM.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    ovf_nxt_s   = ovf_r;
    cnt_nxt_s   = cnt_r;
    len_q_nxt_s = len_q_r;
    if (start_s) begin
      acc_nxt_s   = sx_s;
      ovf_nxt_s   = 1'b0;
      cnt_nxt_s   = LEN_ONE;
      len_q_nxt_s = len_eff_s;
      state_nxt_s = (len_eff_s == LEN_ONE) ? HOLD : ACC;
    end else begin
      case (state_r)
        ACC: begin
          if (in_xfer_s) begin
            acc_nxt_s = sat_s[ACCW-1:0];
            ovf_nxt_s = ovf_r | sat_s[ACCW];
            cnt_nxt_s = cnt_r + LEN_ONE;
            if ((cnt_r + LEN_ONE) == len_q_r) begin
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = ACC;
            end
          end else begin
            state_nxt_s = ACC;
          end
        end
        HOLD: begin
          if (out_xfer_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        IDLE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, datapath and registered status outputs; reset discards any vector.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r     <= IDLE;
      acc_r       <= {ACCW{1'b0}};
      ovf_r       <= 1'b0;
      cnt_r       <= {LENW{1'b0}};
      len_q_r     <= {LENW{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      ovf_r       <= ovf_nxt_s;
      cnt_r       <= cnt_nxt_s;
      len_q_r     <= len_q_nxt_s;
      out_valid_r <= (state_nxt_s == HOLD);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: tb/tb_mb16_acc.sv
// Bench for mb16_acc: two instances (ACCW=40 and ACCW=34) receive identical
// stimulus and are checked every cycle against a vector-level reference model.
module tb_mb16_acc;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic busy0;
  logic busy1;

  mb16_acc_if #(.WIDTH(16), .ACCW(40), .LENW(8)) b0 ();
  mb16_acc_if #(.WIDTH(16), .ACCW(34), .LENW(8)) b1 ();

  mb16_acc #(.WIDTH(16), .ACCW(40), .LENW(8)) dut0 (
    .CLK(CLK), .RST(RST), .bus(b0.slave), .busy(busy0));
  mb16_acc #(.WIDTH(16), .ACCW(34), .LENW(8)) dut1 (
    .CLK(CLK), .RST(RST), .bus(b1.slave), .busy(busy1));

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state, one slot per instance.
  int      m_accw [2] = '{40, 34};
  bit      m_vec  [2];
  bit      m_have [2];
  longint  m_sum  [2];
  longint  m_res  [2];
  bit      m_ovfa [2];
  bit      m_ovfr [2];
  int      m_cnt  [2];
  int      m_len  [2];

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vec[k] = 1'b0; m_have[k] = 1'b0; m_sum[k] = 0; m_res[k] = 0;
      m_ovfa[k] = 1'b0; m_ovfr[k] = 1'b0; m_cnt[k] = 0; m_len[k] = 0;
    end
  endtask

  // One clock of the vector-level behaviour for instance k.
  task automatic model_step(input int k, input bit v, input int p, input int cl,
                            input bit ordy);
    bit     xin;
    bit     xout;
    longint hi;
    longint lo;
    longint s;
    xin  = v && (!m_have[k] || ordy);
    xout = m_have[k] && ordy;
    if (xout) m_have[k] = 1'b0;
    if (xin) begin
      if (!m_vec[k]) begin
        m_vec[k]  = 1'b1;
        m_len[k]  = (cl == 0) ? 1 : cl;
        m_sum[k]  = 0;
        m_ovfa[k] = 1'b0;
        m_cnt[k]  = 0;
      end
      hi = (64'sd1 <<< (m_accw[k] - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (m_accw[k] - 1));
      s  = m_sum[k] + longint'(p);
      if (s > hi) begin s = hi; m_ovfa[k] = 1'b1; end
      if (s < lo) begin s = lo; m_ovfa[k] = 1'b1; end
      m_sum[k] = s;
      m_cnt[k]++;
      if (m_cnt[k] == m_len[k]) begin
        m_have[k] = 1'b1;
        m_res[k]  = m_sum[k];
        m_ovfr[k] = m_ovfa[k];
        m_vec[k]  = 1'b0;
      end
    end
  endtask

  task automatic check_dut(input int k, input bit ordy, input logic ir, input logic ov,
                           input logic bz, input logic signed [63:0] acc,
                           input logic of);
    check_val($sformatf("d%0d in_ready", k), ir, !m_have[k] || ordy);
    check_val($sformatf("d%0d out_valid", k), ov, m_have[k]);
    check_val($sformatf("d%0d busy", k), bz, m_vec[k] || m_have[k]);
    if (m_have[k]) begin
      check_val($sformatf("d%0d acc_out", k), acc, m_res[k]);
      check_val($sformatf("d%0d ovf", k), of, m_ovfr[k]);
    end
  endtask

  // Apply one cycle of inputs, check the outputs against the model, advance.
  task automatic step(input bit v, input int p, input int cl, input bit ordy);
    b0.in_valid = v; b0.product = p; b0.cfg_len = 8'(cl); b0.out_ready = ordy;
    b1.in_valid = v; b1.product = p; b1.cfg_len = 8'(cl); b1.out_ready = ordy;
    #1;
    check_dut(0, ordy, b0.in_ready, b0.out_valid, busy0, $signed(b0.acc_out), b0.ovf);
    check_dut(1, ordy, b1.in_ready, b1.out_valid, busy1, $signed(b1.acc_out), b1.ovf);
    model_step(0, v, p, cl, ordy);
    model_step(1, v, p, cl, ordy);
    @(posedge CLK);
    #1;
  endtask

  // Hold RST low across one rising edge with live inputs, then check cleared outputs.
  task automatic pulse_reset();
    RST = 1'b0;
    b0.in_valid = 1'b1; b1.in_valid = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
    check_val("rst acc0", $signed(b0.acc_out), 64'sd0);
    check_val("rst acc1", $signed(b1.acc_out), 64'sd0);
    check_val("rst ov0", b0.out_valid, 64'sd0);
    check_val("rst ov1", b1.out_valid, 64'sd0);
    check_val("rst ovf0", b0.ovf, 64'sd0);
    check_val("rst busy0", busy0, 64'sd0);
  endtask

  initial begin
    int p;
    int a;
    int b;
    int cl;
    bit sgn;
    model_reset();
    b0.in_valid = 1'b0; b0.product = '0; b0.cfg_len = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.product = '0; b1.cfg_len = '0; b1.out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    pulse_reset();

    // 1: four consecutive terms, single-cycle result pulse.
    step(1'b1, 1000, 4, 1'b1);
    step(1'b1, 2000, 4, 1'b1);
    step(1'b1, -500, 4, 1'b1);
    step(1'b1, 7, 4, 1'b1);
    check_val("t1 acc", $signed(b0.acc_out), 64'sd2507);
    check_val("t1 valid", b0.out_valid, 64'sd1);
    step(1'b0, 0, 4, 1'b1);

    // 2: saturation on the narrow instance, then a clean len=1 vector back-to-back.
    repeat (5) step(1'b1, 32'h7FFF_FFFF, 5, 1'b1);
    check_val("t2 sat acc", $signed(b1.acc_out), 64'sd8589934591);
    check_val("t2 sat ovf", b1.ovf, 64'sd1);
    check_val("t2 wide acc", $signed(b0.acc_out), 64'sd10737418235);
    check_val("t2 wide ovf", b0.ovf, 64'sd0);
    step(1'b1, -3, 1, 1'b1);
    check_val("t2 next acc", $signed(b1.acc_out), -64'sd3);
    check_val("t2 next ovf", b1.ovf, 64'sd0);
    step(1'b0, 0, 0, 1'b1);

    // 3: backpressure holds the result and stalls input, then handoff + new vector.
    step(1'b1, 11, 2, 1'b0);
    step(1'b1, 12, 2, 1'b0);
    repeat (5) step(1'b1, 99, 3, 1'b0);
    check_val("t3 held acc", $signed(b0.acc_out), 64'sd23);
    check_val("t3 held rdy", b0.in_ready, 64'sd0);
    step(1'b1, 40, 1, 1'b1);
    check_val("t3 next acc", $signed(b0.acc_out), 64'sd40);
    step(1'b0, 0, 0, 1'b1);

    // 4: cfg_len 0 behaves as 1; len=1 streams one result per cycle.
    step(1'b1, -1073709056, 0, 1'b1);
    check_val("t4 len0 acc", $signed(b0.acc_out), -64'sd1073709056);
    step(1'b1, -1073709056, 1, 1'b1);
    check_val("t4 len1 acc", $signed(b0.acc_out), -64'sd1073709056);
    step(1'b1, 123, 1, 1'b1);
    check_val("t4 stream acc", $signed(b0.acc_out), 64'sd123);
    step(1'b0, 0, 0, 1'b1);

    // 5: bubbles between terms; mid-vector cfg_len change is ignored.
    step(1'b1, 5, 3, 1'b1);
    step(1'b0, 0, 9, 1'b1);
    step(1'b0, 0, 9, 1'b1);
    step(1'b1, 6, 9, 1'b1);
    step(1'b0, 0, 9, 1'b1);
    step(1'b1, 7, 9, 1'b1);
    check_val("t5 acc", $signed(b0.acc_out), 64'sd18);
    step(1'b0, 0, 0, 1'b1);

    // 6: reset aborts a partial vector; the next vector has no residue.
    step(1'b1, 100, 4, 1'b1);
    step(1'b1, 200, 4, 1'b1);
    pulse_reset();
    step(1'b1, 10, 2, 1'b1);
    step(1'b1, 20, 2, 1'b1);
    check_val("t6 acc", $signed(b0.acc_out), 64'sd30);
    step(1'b0, 0, 0, 1'b1);

    // Randomized traffic: bubbles, backpressure, shifting lengths, extreme products.
    sgn = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 64) == 0) sgn = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) cl = $urandom_range(0, 255);
      else cl = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) begin
        p = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        a = $urandom_range(0, 65535) - 32768;
        b = $urandom_range(0, 65535) - 32768;
        p = a * b;
      end
      step($urandom_range(0, 3) != 0, p, cl, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
